ovl_fire_collector: RTL
=======================

# ovl_fire_collector

Collects the 3-bit `fire` vectors from up to NUM_CHECKERS OVL checkers (ovl_never, ovl_always, etc.) and shares one report channel between them using a round-robin arbiter. Each fire event is latched in a per-checker sticky pending register and reported once over a valid/ready handshake to a logger or CPU-visible mailbox. The block sits beside the checker instances in the verification/monitor subsystem. It also keeps a saturating error count, a lost-event flag and an interrupt line.

## Interface
- NUM_CHECKERS, 4, number of checker fire buses (2..32)
- COUNT_WIDTH, 16, width of total_errors
- clock  input  1  sampling clock, rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  capture enable; when low, fire_in is ignored
- fire_in  input  3*NUM_CHECKERS  checker i occupies bits [3i+2:3i]; bit0 = 2-state error, bit1 = X-check error, bit2 = cover
- rpt_valid  output  1  report available
- rpt_ready  input  1  consumer accepts report
- rpt_id  output  $clog2(NUM_CHECKERS)  index of the reported checker
- rpt_type  output  3  pending fire bits of the reported checker
- total_errors  output  COUNT_WIDTH  accepted reports with rpt_type[1:0] != 0, saturating
- overflow  output  1  sticky; an event was lost
- irq  output  1  level; any error bit pending or being presented

## Operation
- pending[i][2:0] is sticky.
  - Each edge with enable=1: pending |= fire_in slice, after the Configuration mask is applied.
- State machine:
  - IDLE: if any pending != 0, grant the first non-zero checker at or after rr_ptr (wrapping). Load rpt_id and rpt_type = pending[grant]. Go to PRESENT.
  - PRESENT: rpt_valid=1. rpt_id and rpt_type are held stable until accepted.
    - On rpt_valid & rpt_ready: clear the reported bits from pending[rpt_id]. A new fire on the same checker in the same cycle wins and re-sets its bit. Set rr_ptr = rpt_id+1, wrapping at NUM_CHECKERS.
    - After acceptance, if another checker (or the same one again) has pending bits, load the next grant immediately and stay in PRESENT (back-to-back). Otherwise go to IDLE.
- The snapshot in rpt_type does not change while PRESENT. Fires arriving meanwhile accumulate in pending.
- overflow sets when a fire bit arrives for a checker whose same pending bit is already 1 and that bit is not being cleared this cycle. It clears only on reset.
- total_errors increments by 1 on each accepted report with rpt_type[0]|rpt_type[1]. It holds at all-ones.
- irq = (|pending[*][1:0]) | (rpt_valid & |rpt_type[1:0]).
- enable=0 does not stop draining of already-pending reports.

## Timing
- Reset values: rpt_valid=0, rpt_id=0, rpt_type=0, total_errors=0, overflow=0, irq=0. Also pending=0, rr_ptr=0, state=IDLE.
- Latency: a fire sampled at edge t sets pending after edge t. rpt_valid rises after edge t+1.
- Throughput: one report per cycle while rpt_ready=1 and work is pending.
- A report is transferred only on a cycle with valid&ready. The consumer may hold rpt_ready high indefinitely.
- Reset asserted mid-operation clears all state asynchronously. An unaccepted report is discarded.
- Simultaneous fires on several checkers are all captured in one cycle and reported in round-robin order.

## Configuration
- OVL_FIRE_COLLECTOR_COVER_EN:
  - Defined: fire bit2 (cover) is captured, reported and checked for overflow like the error bits.
  - Not defined: bit2 of every slice is masked to 0 before capture, and rpt_type[2] is constant 0.
- The macro never affects total_errors or irq.

## Structure
- Package ovl_fire_pkg holds:
  - FIRE_WIDTH=3 and the bit indices FIRE_2STATE=0, FIRE_XCHECK=1, FIRE_COVER=2
  - the state typedef {IDLE, PRESENT}
- Sub-module ovl_rr_arbiter: parameterised NUM_CHECKERS request vector plus rr_ptr in, one-hot/index grant out, purely combinational.

## Test plan
- Reset, then fire_in checker2 bit0 for one cycle → rpt_valid after 2 edges with rpt_id=2 and rpt_type=3'b001. With ready=1 it is accepted, total_errors=1, irq drops.
- Checkers 0, 1 and 3 fire together with ready=1 → reports id 0, 1, 3 on three consecutive cycles, and rr_ptr ends at 0.
- Hold ready=0, fire checker1 bit1 twice, 3 cycles apart → rpt_type stays 3'b010, overflow=1, and a single report follows when ready=1.
- Cover-only fire on checker0 → with the macro defined, rpt_type=3'b100 and total_errors is unchanged. Without it, no report is produced.
- Force total_errors to all-ones minus 1 and accept 3 error reports → total_errors saturates at all-ones.
- Drop reset mid-PRESENT → rpt_valid=0 immediately. After release there is no report until a new fire arrives. enable=0 with fires present → nothing is captured.

Source files
------------

// File: rtl/ovl_fire_pkg.sv
// Shared types and constants for the OVL fire collector.
package ovl_fire_pkg;

    localparam int unsigned FIRE_WIDTH  = 3;
    localparam int unsigned FIRE_2STATE = 0;
    localparam int unsigned FIRE_XCHECK = 1;
    localparam int unsigned FIRE_COVER  = 2;

    typedef enum logic [0:0] {
        IDLE,
        PRESENT
    } state_t;

endpackage

// File: rtl/ovl_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after rr_ptr, wrapping.
module ovl_rr_arbiter #(
    parameter int unsigned NUM_CHECKERS = 4,
    localparam int unsigned ID_WIDTH = $clog2(NUM_CHECKERS)
) (
    input  logic [NUM_CHECKERS-1:0] req,
    input  logic [ID_WIDTH-1:0]     rr_ptr,
    output logic                    grant_valid,
    output logic [ID_WIDTH-1:0]     grant_id,
    output logic [NUM_CHECKERS-1:0] grant_onehot
);

    int unsigned idx;

    always_comb begin
        grant_valid  = 1'b0;
        grant_id     = '0;
        grant_onehot = '0;
        idx          = 0;
        for (int unsigned k = 0; k < NUM_CHECKERS; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_CHECKERS;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = ID_WIDTH'(idx);
            end
        end
        if (grant_valid) begin
            grant_onehot = NUM_CHECKERS'(1) << grant_id;
        end
    end

endmodule

// File: rtl/ovl_fire_collector.sv
// Collects OVL checker fire vectors and reports them one at a time, round-robin.
// Define OVL_FIRE_COLLECTOR_COVER_EN to capture and report the cover bit as well.
module ovl_fire_collector
    import ovl_fire_pkg::*;
#(
    parameter int unsigned NUM_CHECKERS = 4,
    parameter int unsigned COUNT_WIDTH  = 16,
    localparam int unsigned ID_WIDTH = $clog2(NUM_CHECKERS)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [FIRE_WIDTH*NUM_CHECKERS-1:0] fire_in,
    output logic                               rpt_valid,
    input  logic                               rpt_ready,
    output logic [ID_WIDTH-1:0]                rpt_id,
    output logic [FIRE_WIDTH-1:0]              rpt_type,
    output logic [COUNT_WIDTH-1:0]             total_errors,
    output logic                               overflow,
    output logic                               irq
);

`ifdef OVL_FIRE_COLLECTOR_COVER_EN
    localparam logic [FIRE_WIDTH-1:0] CAPTURE_MASK = 3'b111;
`else
    localparam logic [FIRE_WIDTH-1:0] CAPTURE_MASK = 3'b011;
`endif

    state_t                  state_q, state_d;
    logic [FIRE_WIDTH-1:0]   pending_q [NUM_CHECKERS];
    logic [FIRE_WIDTH-1:0]   pending_d [NUM_CHECKERS];
    logic [FIRE_WIDTH-1:0]   fire_m    [NUM_CHECKERS];
    logic [FIRE_WIDTH-1:0]   avail     [NUM_CHECKERS];
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]     rpt_id_q, rpt_id_d;
    logic [FIRE_WIDTH-1:0]   rpt_type_q, rpt_type_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    accept;
    logic                    lost;
    logic                    err_pending;
    logic [ID_WIDTH-1:0]     next_ptr;
    logic [ID_WIDTH-1:0]     arb_ptr;
    logic [NUM_CHECKERS-1:0] req;
    logic                    grant_valid;
    logic [ID_WIDTH-1:0]     grant_id;
    logic [NUM_CHECKERS-1:0] grant_onehot;
    logic [FIRE_WIDTH-1:0]   grant_type;

    assign accept   = (state_q == PRESENT) && rpt_ready;
    assign next_ptr = (32'(rpt_id_q) == NUM_CHECKERS - 1) ? '0 : rpt_id_q + 1'b1;
    // After an accept the next grant already starts after the checker just served.
    assign arb_ptr  = accept ? next_ptr : rr_ptr_q;

    // Capture: the bits being reported are cleared, but a same-cycle fire re-sets them.
    always_comb begin
        lost        = 1'b0;
        err_pending = 1'b0;
        req         = '0;
        for (int unsigned i = 0; i < NUM_CHECKERS; i++) begin
            fire_m[i] = enable ? (fire_in[FIRE_WIDTH*i +: FIRE_WIDTH] & CAPTURE_MASK) : '0;
            avail[i]  = pending_q[i];
            if (accept && (32'(rpt_id_q) == i)) begin
                avail[i] = pending_q[i] & ~rpt_type_q;
            end
            req[i]       = |avail[i];
            pending_d[i] = avail[i] | fire_m[i];
            lost         = lost | (|(fire_m[i] & avail[i]));
            err_pending  = err_pending | (|pending_q[i][FIRE_XCHECK:FIRE_2STATE]);
        end
    end

    ovl_rr_arbiter #(
        .NUM_CHECKERS(NUM_CHECKERS)
    ) u_arbiter (
        .req         (req),
        .rr_ptr      (arb_ptr),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .grant_onehot(grant_onehot)
    );

    always_comb begin
        grant_type = '0;
        for (int unsigned i = 0; i < NUM_CHECKERS; i++) begin
            if (grant_onehot[i]) begin
                grant_type = grant_type | avail[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rpt_id_d   = rpt_id_q;
        rpt_type_d = rpt_type_q;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    rpt_id_d   = grant_id;
                    rpt_type_d = grant_type;
                    state_d    = PRESENT;
                end
            end
            PRESENT: begin
                if (rpt_ready) begin
                    rr_ptr_d = next_ptr;
                    if (grant_valid) begin
                        rpt_id_d   = grant_id;
                        rpt_type_d = grant_type;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q | lost;
        if (accept && (|rpt_type_q[FIRE_XCHECK:FIRE_2STATE]) && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            rpt_id_q   <= '0;
            rpt_type_q <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_CHECKERS; i++) begin
                pending_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            rpt_id_q   <= rpt_id_d;
            rpt_type_q <= rpt_type_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            for (int unsigned i = 0; i < NUM_CHECKERS; i++) begin
                pending_q[i] <= pending_d[i];
            end
        end
    end

    assign rpt_valid    = (state_q == PRESENT);
    assign rpt_id       = rpt_id_q;
    assign rpt_type     = rpt_type_q;
    assign total_errors = count_q;
    assign overflow     = overflow_q;
    assign irq          = err_pending
                        | (rpt_valid & (|rpt_type_q[FIRE_XCHECK:FIRE_2STATE]));

endmodule
